// File: rtl/instr_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instr_controller: fetch/decode/execute sequencer between PC/imem and datapath |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module instr_controller #(
  parameter int         IW      = 16,
  parameter logic [2:0] ALU_ADD = 3'b001,
  parameter logic [2:0] ALU_SUB = 3'b010
) (
  input  logic          clk,
  input  logic          clear,
  input  logic [IW-1:0] instr,
  output logic          pc_clr,
  output logic          pc_up,
  output logic [7:0]    d_addr,
  output logic          d_wr,
  output logic          rf_s,
  output logic [3:0]    rf_w_addr,
  output logic          rf_w_en,
  output logic [3:0]    rf_ra_addr,
  output logic [3:0]    rf_rb_addr,
  output logic [2:0]    alu_s,
  output logic [3:0]    state_out
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam logic [3:0] OP_NOOP  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_LOAD  = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_HALT  = 4'b0101;

  state_t        state_q, state_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [3:0]    opcode;

  assign opcode    = ir_q[IW-1:IW-4];
  assign state_out = state_q;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= S_INIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    pc_clr     = 1'b0;
    pc_up      = 1'b0;
    d_addr     = 8'h00;
    d_wr       = 1'b0;
    rf_s       = 1'b0;
    rf_w_addr  = 4'h0;
    rf_w_en    = 1'b0;
    rf_ra_addr = 4'h0;
    rf_rb_addr = 4'h0;
    alu_s      = 3'b000;
    case (state_q)
      S_INIT: begin
        pc_clr  = 1'b1;
        state_d = S_FETCH;
      end
      // PC advances on this same edge, so IR captures the word at the old PC
      S_FETCH: begin
        pc_up   = 1'b1;
        ir_d    = instr;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_NOOP:  state_d = S_NOOP;
          OP_STORE: state_d = S_STORE;
          OP_LOAD:  state_d = S_LOAD_A;
          OP_ADD:   state_d = S_ADD;
          OP_SUB:   state_d = S_SUB;
          OP_HALT:  state_d = S_HALT;
          default:  state_d = S_NOOP;
        endcase
      end
      S_NOOP: state_d = S_FETCH;
      // First load cycle only covers the data memory read latency
      S_LOAD_A: begin
        d_addr  = ir_q[11:4];
        rf_s    = 1'b1;
        state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        d_addr    = ir_q[11:4];
        rf_s      = 1'b1;
        rf_w_addr = ir_q[3:0];
        rf_w_en   = 1'b1;
        state_d   = S_FETCH;
      end
      S_STORE: begin
        d_addr     = ir_q[7:0];
        rf_ra_addr = ir_q[11:8];
        d_wr       = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADD, S_SUB: begin
        rf_ra_addr = ir_q[11:8];
        rf_rb_addr = ir_q[7:4];
        rf_w_addr  = ir_q[3:0];
        rf_w_en    = 1'b1;
        alu_s      = (state_q == S_ADD) ? ALU_ADD : ALU_SUB;
        state_d    = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_INIT;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_instr_controller: random program run against a per-instruction model     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_instr_controller;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_clr;
    logic       pc_up;
    logic [7:0] d_addr;
    logic       d_wr;
    logic       rf_s;
    logic [3:0] rf_w_addr;
    logic       rf_w_en;
    logic [3:0] rf_ra_addr;
    logic [3:0] rf_rb_addr;
    logic [2:0] alu_s;
  } obs_t;

  logic        clk;
  logic        clear;
  logic [15:0] instr;
  logic        pc_clr, pc_up, d_wr, rf_s, rf_w_en;
  logic [7:0]  d_addr;
  logic [3:0]  rf_w_addr, rf_ra_addr, rf_rb_addr, state_out;
  logic [2:0]  alu_s;

  logic [15:0] mem [128];
  logic [6:0]  pc;
  obs_t        act;
  obs_t        exp_q [$];
  int          checks;
  int          errors;
  logic [6:0]  exp_pc;

  instr_controller #(.IW(16), .ALU_ADD(3'b001), .ALU_SUB(3'b010)) dut (
    .clk        (clk),
    .clear      (clear),
    .instr      (instr),
    .pc_clr     (pc_clr),
    .pc_up      (pc_up),
    .d_addr     (d_addr),
    .d_wr       (d_wr),
    .rf_s       (rf_s),
    .rf_w_addr  (rf_w_addr),
    .rf_w_en    (rf_w_en),
    .rf_ra_addr (rf_ra_addr),
    .rf_rb_addr (rf_rb_addr),
    .alu_s      (alu_s),
    .state_out  (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment: 7-bit program counter plus instruction memory
  always @(posedge clk) begin
    if (pc_clr)     pc <= 7'd0;
    else if (pc_up) pc <= pc + 7'd1;
  end
  always_comb instr = mem[pc];

  assign act = {state_out, pc_clr, pc_up, d_addr, d_wr, rf_s,
                rf_w_addr, rf_w_en, rf_ra_addr, rf_rb_addr, alu_s};

  function automatic obs_t idle(input logic [3:0] st);
    obs_t r;
    r    = '0;
    r.st = st;
    return r;
  endfunction

  // Expected cycle-by-cycle outputs for one instruction word
  function automatic void plan(input logic [15:0] w);
    obs_t r;
    r = idle(4'd1); r.pc_up = 1'b1; exp_q.push_back(r);
    exp_q.push_back(idle(4'd2));
    case (w[15:12])
      4'h1: begin
        r = idle(4'd6); r.d_wr = 1'b1; r.d_addr = w[7:0]; r.rf_ra_addr = w[11:8];
        exp_q.push_back(r);
      end
      4'h2: begin
        r = idle(4'd4); r.d_addr = w[11:4]; r.rf_s = 1'b1;
        exp_q.push_back(r);
        r.st = 4'd5; r.rf_w_addr = w[3:0]; r.rf_w_en = 1'b1;
        exp_q.push_back(r);
      end
      4'h3, 4'h4: begin
        r = idle((w[15:12] == 4'h3) ? 4'd7 : 4'd8);
        r.rf_ra_addr = w[11:8]; r.rf_rb_addr = w[7:4];
        r.rf_w_addr  = w[3:0];  r.rf_w_en    = 1'b1;
        r.alu_s      = (w[15:12] == 4'h3) ? 3'b001 : 3'b010;
        exp_q.push_back(r);
      end
      4'h5: exp_q.push_back(idle(4'd9));
      default: exp_q.push_back(idle(4'd3));
    endcase
  endfunction

  task automatic check(input string tag, input obs_t e);
    checks += 2;
    assert (act.st === e.st) else begin
      errors++;
      $error("FAIL %s state_out: observed %0d expected %0d", tag, act.st, e.st);
    end
    assert (act[27:0] === e[27:0]) else begin
      errors++;
      $error("FAIL %s outputs: observed %h expected %h (state %0d)", tag, act[27:0], e[27:0], e.st);
    end
  endtask

  task automatic run_instrs(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      plan(mem[exp_pc]);
      exp_pc = exp_pc + 7'd1;
      while (exp_q.size() > 0) begin
        @(negedge clk);
        check(tag, exp_q.pop_front());
      end
    end
  endtask

  task automatic release_and_check_init(input string tag);
    obs_t r;
    clear = 1'b0;
    #1;
    r = idle(4'd0); r.pc_clr = 1'b1;
    check(tag, r);
    exp_pc = 7'd0;
  endtask

  initial begin
    obs_t r;
    checks = 0;
    errors = 0;
    clear  = 1'b1;
    for (int i = 0; i < 128; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 14));
      if (op >= 4'd5) op = op + 4'd1;
      mem[i] = {op, 12'($urandom)};
    end
    mem[0] = 16'h2A53;
    mem[1] = 16'h1742;
    mem[2] = 16'h3123;
    mem[3] = 16'h4123;
    mem[4] = 16'hF000;

    repeat (2) @(negedge clk);
    r = idle(4'd0); r.pc_clr = 1'b1;
    check("reset_held", r);
    release_and_check_init("init_after_reset");

    // 200 instructions wraps the 128-word program
    run_instrs(200, "random_prog");

    // Asynchronous clear mid-cycle, seen before any clock edge
    @(posedge clk);
    #3 clear = 1'b1;
    #1;
    r = idle(4'd0); r.pc_clr = 1'b1;
    check("async_clear", r);
    repeat (2) @(negedge clk);
    release_and_check_init("init_after_async");

    // Abort a LOAD while it is in its register-write cycle
    plan(mem[0]);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      check("load_before_abort", exp_q.pop_front());
    end
    #2 clear = 1'b1;
    #1;
    r = idle(4'd0); r.pc_clr = 1'b1;
    check("load_b_abort", r);
    repeat (2) @(negedge clk);
    release_and_check_init("init_after_abort");

    run_instrs(5, "directed_prog");

    // HALT parks the controller with no PC advance
    mem[5] = 16'h5000;
    plan(mem[exp_pc]);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      check("halt_entry", exp_q.pop_front());
    end
    repeat (24) begin
      @(negedge clk);
      check("halt_hold", idle(4'd9));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_controller.md
Name: instr_controller

Overview:
- Fetch/decode/execute controller for the ProjectB processor.
- Drives the program counter's `up`/`clear` inputs and latches the instruction word that instruction memory returns at the PC address.
- Decodes the latched instruction and sequences the data memory, register file and ALU control lines one state at a time.
- Sits between the PC/instruction memory pair and the datapath.

Parameters:
- IW, 16, instruction word width. Opcode is always IW-1:IW-4.
- ALU_ADD, 3'b001, ALU select code driven for ADD.
- ALU_SUB, 3'b010, ALU select code driven for SUB.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- clear  in  1  asynchronous, active-high reset
- instr  in  IW  instruction memory read data for the current PC address; combinationally valid from the PC
- pc_clr  out  1  to PC counter `clear`
- pc_up  out  1  to PC counter `up`
- d_addr  out  8  data memory address
- d_wr  out  1  data memory write enable
- rf_s  out  1  register-file write mux select: 1 = data memory, 0 = ALU
- rf_w_addr  out  4  register-file write address
- rf_w_en  out  1  register-file write enable
- rf_ra_addr  out  4  register-file read port A address
- rf_rb_addr  out  4  register-file read port B address
- alu_s  out  3  ALU function select
- state_out  out  4  current state encoding, for display/debug

Behaviour:
- Internal registers: state (4 bits) and IR (IW bits). All outputs are combinational functions of state and IR (Moore).

Instruction formats:
- NOOP 0000.
- STORE 0001: IR[11:8] = ra, IR[7:0] = d_addr.
- LOAD 0010: IR[11:4] = d_addr, IR[3:0] = rd.
- ADD 0011 and SUB 0100: IR[11:8] = ra, IR[7:4] = rb, IR[3:0] = rd.
- HALT 0101.
- Opcodes 0110–1111 execute as NOOP.

State encodings (state_out):
- INIT=0, FETCH=1, DECODE=2, NOOP=3, LOAD_A=4, LOAD_B=5, STORE=6, ADD=7, SUB=8, HALT=9.

Default outputs:
- Every output is 0 unless its state sets it below.

Reset:
- clear=1 forces state=INIT and IR=0 immediately, without waiting for clk.
- While clear is held: pc_clr=1, all other outputs 0, state_out=0.
- Reset mid-instruction aborts the instruction. A pending d_wr or rf_w_en drops immediately.

States and transitions:
- INIT: pc_clr=1. Next: FETCH.
- FETCH: pc_up=1. IR <= instr at the clock edge. Next: DECODE.
  - The PC advances on the same edge, so IR holds the word at the old PC.
- DECODE: no strobes. Next state chosen by IR[15:12]: 0000→NOOP, 0001→STORE, 0010→LOAD_A, 0011→ADD, 0100→SUB, 0101→HALT, other→NOOP.
- NOOP: Next: FETCH.
- LOAD_A: d_addr=IR[11:4], rf_s=1. Next: LOAD_B.
  - This cycle covers data memory read latency.
- LOAD_B: d_addr=IR[11:4], rf_s=1, rf_w_addr=IR[3:0], rf_w_en=1. Next: FETCH.
- STORE: d_addr=IR[7:0], rf_ra_addr=IR[11:8], d_wr=1. Next: FETCH.
- ADD: rf_ra_addr=IR[11:8], rf_rb_addr=IR[7:4], rf_w_addr=IR[3:0], rf_w_en=1, rf_s=0, alu_s=ALU_ADD. Next: FETCH.
- SUB: same as ADD, with alu_s=ALU_SUB.
- HALT: all strobes 0. Stays in HALT until clear. pc_up is never asserted here.

Latency (cycles per instruction, including FETCH and DECODE):
- NOOP / STORE / ADD / SUB: 3.
- LOAD: 4.
- INIT: 1 cycle after reset release.

Other rules:
- IR changes only in FETCH.
- pc_up and pc_clr are never both 1.
- PC wrap from 127 to 0 is the counter's concern. The controller continues fetching normally.

Test Plan:
- Reset: assert clear mid-cycle → state_out=0 and pc_clr=1 without a clock edge. Release → next edges give state_out 1 then 2. pc_up=1 only during FETCH.
- LOAD instr=16'h2A53 → LOAD_A shows d_addr=8'hA5, rf_s=1, rf_w_en=0. LOAD_B adds rf_w_addr=3, rf_w_en=1. Then FETCH. Total 4 cycles.
- STORE instr=16'h1742 → STORE state shows d_wr=1, d_addr=8'h42, rf_ra_addr=7. Next cycle d_wr=0 and state=FETCH.
- ADD 16'h3123 / SUB 16'h4123 → ra=1, rb=2, rd=3, rf_w_en=1, rf_s=0, alu_s=001 / 010 respectively.
- HALT 16'h5000 → state_out=9 held for ≥20 cycles with pc_up=0. Opcode 16'hF000 → NOOP path (state_out 3), no strobes.
- Assert clear while in LOAD_B → rf_w_en drops immediately and state_out=0. Program restarts from INIT with pc_clr=1.
